fsk_nco_ctrl: RTL and testbench
===============================

Name: fsk_nco_ctrl

Overview:
Symbol-rate controller that sequences the NCO core (`dds`) for 2-FSK modulation. It latches the carrier and deviation configuration and gates the NCO clock enable. It accepts one data bit per symbol through a valid/ready handshake. For each symbol it drives the NCO `freq_mod_i` with +dev or −dev, and it manages NCO warm-up (waiting for `out_valid`) and pipeline drain on stop.

Parameters:
- PHASE_W, 25: width of the phase-increment and frequency-modulation words.
- SPS, 16: NCO samples per symbol; must be ≥ 2.
- CNT_W, 8: width of the sample and warm-up counters; must satisfy 2^CNT_W > max(SPS, WARM_MAX, NCO_LAT).
- WARM_MAX, 64: cycles allowed for `nco_valid_i` to rise after start before timeout.
- NCO_LAT, 7: drain cycles that keep the NCO clocked after the last symbol.

Ports:
- `clk`, in, 1: system clock.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `enable_i`, in, 1: level; 1 = run the modulator, 0 = stop at the next symbol boundary.
- `phi_base_i`, in, PHASE_W: carrier phase increment; sampled only on IDLE→WARM.
- `dev_i`, in, PHASE_W: unsigned deviation, < 2^(PHASE_W−1); sampled only on IDLE→WARM.
- `bit_i`, in, 1: data bit.
- `bit_valid_i`, in, 1: `bit_i` is valid.
- `bit_ready_o`, out, 1: controller accepts `bit_i` this cycle.
- `phi_inc_o`, out, PHASE_W: to NCO `phi_inc_i`.
- `freq_mod_o`, out, PHASE_W: to NCO `freq_mod_i`, two's complement.
- `nco_clken_o`, out, 1: to NCO `clken`.
- `nco_valid_i`, in, 1: from NCO `out_valid`.
- `sym_start_o`, out, 1: one-cycle pulse on the first sample cycle of each symbol.
- `busy_o`, out, 1: state ≠ IDLE.
- `underrun_o`, out, 1: one-cycle pulse when a symbol boundary passes with no bit available.
- `timeout_o`, out, 1: sticky; set on warm-up timeout, cleared on the next IDLE→WARM.

Behaviour:
- Reset (asynchronous, any state):
  - state = IDLE; all counters = 0.
  - `phi_inc_o`, `freq_mod_o`, `nco_clken_o`, `sym_start_o`, `underrun_o`, `timeout_o` = 0.
  - Takes effect immediately, including mid-symbol.
- States: IDLE, WARM, RUN, DRAIN. All outputs are registered except `bit_ready_o` and `busy_o`, which are combinational from state and counter.
- IDLE:
  - `nco_clken_o` = 0; `bit_ready_o` = 0.
  - On `enable_i` = 1: latch `phi_base_i` → `phi_inc_o` and `dev_i` → internal dev register; set `freq_mod_o` = 0; clear `timeout_o`; warm counter = 0; `nco_clken_o` = 1; go to WARM.
- WARM:
  - `nco_clken_o` = 1; `freq_mod_o` = 0 (unmodulated carrier); warm counter increments each cycle.
  - If `nco_valid_i` = 1: go to RUN and preload sample counter = SPS−1. `nco_valid_i` has priority over timeout in the same cycle.
  - Else if warm counter = WARM_MAX−1: set `timeout_o`; `nco_clken_o` = 0; go to IDLE.
  - `enable_i` is ignored in WARM.
- RUN:
  - `nco_clken_o` = 1 continuously.
  - Sample counter counts 0..SPS−1 and wraps to 0.
  - Boundary cycle (counter = SPS−1):
    - `bit_ready_o` = `enable_i`.
    - Transfer when `bit_valid_i` & `bit_ready_o`. On the next cycle (counter = 0): `freq_mod_o` = `bit_i` ? +dev : −dev, where −dev = (~dev + 1) mod 2^PHASE_W; `sym_start_o` = 1.
    - If `enable_i` = 1 and `bit_valid_i` = 0: next cycle `freq_mod_o` = 0, `underrun_o` = 1, `sym_start_o` = 1, and a carrier symbol is sent for SPS samples.
    - If `enable_i` = 0: go to DRAIN, `freq_mod_o` = 0, drain counter = 0.
  - Outside the boundary, `bit_ready_o` = 0. Deasserting `enable_i` mid-symbol never truncates the symbol.
  - `phi_inc_o` and the dev register are frozen; `phi_base_i` and `dev_i` changes have no effect until the next IDLE→WARM.
- DRAIN:
  - `nco_clken_o` = 1; `freq_mod_o` = 0; counter increments.
  - At counter = NCO_LAT−1: go to IDLE; `nco_clken_o` = 0 from the next cycle.
  - `enable_i` re-asserted during DRAIN is ignored until IDLE is reached.
- Throughput: exactly one bit per SPS cycles while a supply is continuous. `bit_valid_i` held high yields exactly one transfer per symbol.
- `bit_i` may change freely when `bit_ready_o` = 0.

Test Plan:
- Config used below: SPS=16, `phi_base_i`=25'h0600000, `dev_i`=25'h0200000, WARM_MAX=64, NCO_LAT=7.
1. Normal run: `enable_i`=1, `nco_valid_i` rises 5 cycles later, bits 1,0 offered → `phi_inc_o`=25'h0600000; `freq_mod_o`=25'h0200000 for 16 cycles, then 25'h1E00000 for 16 cycles; `sym_start_o` pulses exactly 16 cycles apart.
2. Underrun: `bit_valid_i`=0 at the second boundary → `freq_mod_o`=0 for 16 cycles, one `underrun_o` pulse, `sym_start_o` still pulses; a bit offered later is accepted at the following boundary.
3. Timeout: `nco_valid_i` held 0 → after 64 WARM cycles `timeout_o`=1 (sticky), `nco_clken_o`=0, `busy_o`=0; the next enable clears `timeout_o`.
4. Stop mid-symbol: drop `enable_i` at sample 5 → symbol completes all 16 samples, no `bit_ready_o`, DRAIN holds `freq_mod_o`=0 with `nco_clken_o`=1 for 7 cycles, then `nco_clken_o`=0 and `busy_o`=0.
5. Config freeze and reset: change `phi_base_i` to 25'h0300000 during RUN → `phi_inc_o` stays 25'h0600000; assert `reset_n`=0 mid-symbol → all outputs 0 immediately; after release, state IDLE.
6. Continuous valid: `bit_valid_i`=1 with alternating bits for 8 symbols → exactly 8 transfers, one per 16 cycles, `freq_mod_o` alternating ±dev, no underrun.

Source files
------------

// File: rtl/fsk_nco_ctrl.sv
// 2-FSK symbol-rate controller: sequences an NCO through warm-up, modulated run and drain,
// accepting one data bit per symbol over a valid/ready handshake.
module fsk_nco_ctrl #(
  parameter int PHASE_W  = 25,
  parameter int SPS      = 16,
  parameter int CNT_W    = 8,
  parameter int WARM_MAX = 64,
  parameter int NCO_LAT  = 7
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable_i,
  input  logic [PHASE_W-1:0] phi_base_i,
  input  logic [PHASE_W-1:0] dev_i,
  input  logic               bit_i,
  input  logic               bit_valid_i,
  output logic               bit_ready_o,
  output logic [PHASE_W-1:0] phi_inc_o,
  output logic [PHASE_W-1:0] freq_mod_o,
  output logic               nco_clken_o,
  input  logic               nco_valid_i,
  output logic               sym_start_o,
  output logic               busy_o,
  output logic               underrun_o,
  output logic               timeout_o
);

  typedef enum logic [1:0] {S_IDLE, S_WARM, S_RUN, S_DRAIN} state_t;

  localparam logic [CNT_W-1:0] L_SYM_LAST   = CNT_W'(SPS - 1);
  localparam logic [CNT_W-1:0] L_WARM_LAST  = CNT_W'(WARM_MAX - 1);
  localparam logic [CNT_W-1:0] L_DRAIN_LAST = CNT_W'(NCO_LAT - 1);

  state_t             r_state, w_next_state;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [PHASE_W-1:0] r_dev, w_dev_nxt;
  logic [PHASE_W-1:0] r_phi_inc, w_phi_inc_nxt;
  logic [PHASE_W-1:0] r_freq_mod, w_freq_mod_nxt;
  logic [PHASE_W-1:0] w_dev_neg;
  logic               r_clken, w_clken_nxt;
  logic               r_sym_start, w_sym_start_nxt;
  logic               r_underrun, w_underrun_nxt;
  logic               r_timeout, w_timeout_nxt;
  logic               w_boundary, w_xfer;

  // The last sample of a symbol is the only cycle a new bit can be taken.
  assign w_boundary  = (r_state == S_RUN) && (r_cnt == L_SYM_LAST);
  assign bit_ready_o = w_boundary && enable_i;
  assign busy_o      = (r_state != S_IDLE);
  assign w_xfer      = bit_ready_o && bit_valid_i;
  assign w_dev_neg   = ~r_dev + PHASE_W'(1);

  assign phi_inc_o   = r_phi_inc;
  assign freq_mod_o  = r_freq_mod;
  assign nco_clken_o = r_clken;
  assign sym_start_o = r_sym_start;
  assign underrun_o  = r_underrun;
  assign timeout_o   = r_timeout;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_dev       <= '0;
      r_phi_inc   <= '0;
      r_freq_mod  <= '0;
      r_clken     <= 1'b0;
      r_sym_start <= 1'b0;
      r_underrun  <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_cnt       <= w_cnt_nxt;
      r_dev       <= w_dev_nxt;
      r_phi_inc   <= w_phi_inc_nxt;
      r_freq_mod  <= w_freq_mod_nxt;
      r_clken     <= w_clken_nxt;
      r_sym_start <= w_sym_start_nxt;
      r_underrun  <= w_underrun_nxt;
      r_timeout   <= w_timeout_nxt;
    end
  end

  // A valid NCO output wins over a simultaneous warm-up timeout.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (enable_i) w_next_state = S_WARM;
      S_WARM: begin
        if (nco_valid_i)                w_next_state = S_RUN;
        else if (r_cnt == L_WARM_LAST)  w_next_state = S_IDLE;
      end
      S_RUN:   if (w_boundary && !enable_i) w_next_state = S_DRAIN;
      S_DRAIN: if (r_cnt == L_DRAIN_LAST)   w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_cnt_nxt       = r_cnt;
    w_dev_nxt       = r_dev;
    w_phi_inc_nxt   = r_phi_inc;
    w_freq_mod_nxt  = r_freq_mod;
    w_clken_nxt     = r_clken;
    w_sym_start_nxt = 1'b0;
    w_underrun_nxt  = 1'b0;
    w_timeout_nxt   = r_timeout;
    case (r_state)
      S_IDLE: begin
        w_clken_nxt = 1'b0;
        if (enable_i) begin
          w_phi_inc_nxt  = phi_base_i;
          w_dev_nxt      = dev_i;
          w_freq_mod_nxt = '0;
          w_timeout_nxt  = 1'b0;
          w_cnt_nxt      = '0;
          w_clken_nxt    = 1'b1;
        end
      end
      S_WARM: begin
        w_freq_mod_nxt = '0;
        w_clken_nxt    = 1'b1;
        w_cnt_nxt      = r_cnt + CNT_W'(1);
        // Entering RUN on a boundary lets the first bit be taken immediately.
        if (nco_valid_i) begin
          w_cnt_nxt = L_SYM_LAST;
        end else if (r_cnt == L_WARM_LAST) begin
          w_timeout_nxt = 1'b1;
          w_clken_nxt   = 1'b0;
          w_cnt_nxt     = '0;
        end
      end
      S_RUN: begin
        w_clken_nxt = 1'b1;
        if (w_boundary) begin
          w_cnt_nxt = '0;
          if (!enable_i) begin
            w_freq_mod_nxt = '0;
          end else begin
            w_sym_start_nxt = 1'b1;
            if (w_xfer) begin
              w_freq_mod_nxt = bit_i ? r_dev : w_dev_neg;
            end else begin
              w_freq_mod_nxt = '0;
              w_underrun_nxt = 1'b1;
            end
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_DRAIN: begin
        w_freq_mod_nxt = '0;
        if (r_cnt == L_DRAIN_LAST) begin
          w_clken_nxt = 1'b0;
          w_cnt_nxt   = '0;
        end else begin
          w_clken_nxt = 1'b1;
          w_cnt_nxt   = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_clken_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_fsk_nco_ctrl.sv
// Directed bench for fsk_nco_ctrl: normal run, underrun, timeout, stop/drain, config freeze,
// asynchronous reset and continuous supply; inputs change and outputs are sampled on negedges.
module tb_fsk_nco_ctrl;

  localparam int PW  = 25;
  localparam int SPS = 16;
  localparam logic [PW-1:0] PHI  = 25'h0600000;
  localparam logic [PW-1:0] DEV  = 25'h0200000;
  localparam logic [PW-1:0] NDEV = 25'h1E00000;

  logic          clk;
  logic          reset_n;
  logic          enable_i;
  logic [PW-1:0] phi_base_i;
  logic [PW-1:0] dev_i;
  logic          bit_i;
  logic          bit_valid_i;
  logic          bit_ready_o;
  logic [PW-1:0] phi_inc_o;
  logic [PW-1:0] freq_mod_o;
  logic          nco_clken_o;
  logic          nco_valid_i;
  logic          sym_start_o;
  logic          busy_o;
  logic          underrun_o;
  logic          timeout_o;

  int checks = 0;
  int failures = 0;
  int xfers = 0;
  int xferBase;
  int bad;

  fsk_nco_ctrl #(
    .PHASE_W(PW), .SPS(SPS), .CNT_W(8), .WARM_MAX(64), .NCO_LAT(7)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable_i(enable_i),
    .phi_base_i(phi_base_i), .dev_i(dev_i),
    .bit_i(bit_i), .bit_valid_i(bit_valid_i), .bit_ready_o(bit_ready_o),
    .phi_inc_o(phi_inc_o), .freq_mod_o(freq_mod_o), .nco_clken_o(nco_clken_o),
    .nco_valid_i(nco_valid_i), .sym_start_o(sym_start_o), .busy_o(busy_o),
    .underrun_o(underrun_o), .timeout_o(timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bit_valid_i && bit_ready_o) xfers++;
  end

  task automatic applyStimulus(input logic en, input logic bv, input logic b, input logic nv);
    enable_i    = en;
    bit_valid_i = bv;
    bit_i       = b;
    nco_valid_i = nv;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts on the first sample of a symbol and walks to its last sample (or to stopAt).
  task automatic checkSymbol(input string tag, input logic [PW-1:0] expFreq, input logic expUnd,
                             input int dropAt, input int stopAt);
    int errs;
    int lastK;
    errs  = 0;
    lastK = (stopAt > 0) ? stopAt : SPS - 1;
    checkOutput({tag, "_start"}, sym_start_o, 1);
    checkOutput({tag, "_freq"}, freq_mod_o, expFreq);
    checkOutput({tag, "_underrun"}, underrun_o, expUnd);
    for (int k = 1; k <= lastK; k++) begin
      @(negedge clk);
      if (k == dropAt) enable_i = 1'b0;
      if (sym_start_o !== 1'b0 || underrun_o !== 1'b0 || freq_mod_o !== expFreq ||
          nco_clken_o !== 1'b1 || busy_o !== 1'b1) errs++;
      if (k < SPS - 1 && bit_ready_o !== 1'b0) errs++;
    end
    checkOutput({tag, "_hold"}, errs, 0);
  endtask

  initial begin
    reset_n    = 1'b0;
    phi_base_i = '0;
    dev_i      = '0;
    applyStimulus(0, 0, 0, 0);
    repeat (2) @(negedge clk);
    checkOutput("rst_phi", phi_inc_o, 0);
    checkOutput("rst_freq", freq_mod_o, 0);
    checkOutput("rst_clken", nco_clken_o, 0);
    checkOutput("rst_sym", sym_start_o, 0);
    checkOutput("rst_und", underrun_o, 0);
    checkOutput("rst_tout", timeout_o, 0);
    checkOutput("rst_busy", busy_o, 0);
    checkOutput("rst_ready", bit_ready_o, 0);
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_busy", busy_o, 0);

    // Normal run: warm-up, then bits 1 and 0.
    phi_base_i = PHI;
    dev_i      = DEV;
    applyStimulus(1, 0, 0, 0);
    @(negedge clk);
    checkOutput("warm_phi", phi_inc_o, PHI);
    checkOutput("warm_clken", nco_clken_o, 1);
    checkOutput("warm_busy", busy_o, 1);
    checkOutput("warm_freq", freq_mod_o, 0);
    checkOutput("warm_ready", bit_ready_o, 0);
    repeat (4) @(negedge clk);
    applyStimulus(1, 1, 1, 1);
    @(negedge clk);
    #1 checkOutput("run_first_ready", bit_ready_o, 1);
    checkOutput("run_first_sym", sym_start_o, 0);
    @(negedge clk);
    applyStimulus(1, 1, 0, 1);
    checkSymbol("s1", DEV, 0, -1, -1);
    #1 checkOutput("s1_ready", bit_ready_o, 1);
    @(negedge clk);
    applyStimulus(1, 0, 0, 1);
    checkSymbol("s2", NDEV, 0, -1, -1);
    #1 checkOutput("s2_ready", bit_ready_o, 1);

    // Underrun, then a late bit accepted at the following boundary.
    @(negedge clk);
    checkSymbol("s3_underrun", '0, 1, -1, -1);
    applyStimulus(1, 1, 1, 1);
    #1 checkOutput("s3_ready", bit_ready_o, 1);

    // Stop mid-symbol: the symbol completes, then drains.
    @(negedge clk);
    applyStimulus(1, 0, 0, 1);
    checkSymbol("s4_stop", DEV, 0, 5, -1);
    #1 checkOutput("s4_noready", bit_ready_o, 0);
    bad = 0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (nco_clken_o !== 1'b1 || freq_mod_o !== '0 || busy_o !== 1'b1 ||
          sym_start_o !== 1'b0 || underrun_o !== 1'b0) bad++;
    end
    checkOutput("drain_hold", bad, 0);
    @(negedge clk);
    checkOutput("drain_end_clken", nco_clken_o, 0);
    checkOutput("drain_end_busy", busy_o, 0);

    // Warm-up timeout; enable dropped inside WARM must be ignored.
    applyStimulus(1, 0, 0, 0);
    @(negedge clk);
    applyStimulus(0, 0, 0, 0);
    checkOutput("tout_warm_busy", busy_o, 1);
    repeat (63) @(negedge clk);
    checkOutput("tout_last_busy", busy_o, 1);
    checkOutput("tout_last_clken", nco_clken_o, 1);
    checkOutput("tout_last_flag", timeout_o, 0);
    @(negedge clk);
    checkOutput("tout_flag", timeout_o, 1);
    checkOutput("tout_clken", nco_clken_o, 0);
    checkOutput("tout_busy", busy_o, 0);
    repeat (3) @(negedge clk);
    checkOutput("tout_sticky", timeout_o, 1);

    // Re-enable clears timeout; config changes during RUN are ignored; reset mid-symbol.
    phi_base_i = PHI;
    dev_i      = DEV;
    applyStimulus(1, 0, 0, 1);
    @(negedge clk);
    checkOutput("reen_tout", timeout_o, 0);
    checkOutput("reen_busy", busy_o, 1);
    @(negedge clk);
    phi_base_i = 25'h0300000;
    dev_i      = 25'h0100000;
    applyStimulus(1, 1, 0, 1);
    #1 checkOutput("s5_ready", bit_ready_o, 1);
    @(negedge clk);
    checkSymbol("s5_frozen", NDEV, 0, -1, -1);
    checkOutput("s5_phi", phi_inc_o, PHI);
    @(negedge clk);
    checkSymbol("s6_partial", NDEV, 0, -1, 7);
    reset_n = 1'b0;
    #1;
    checkOutput("arst_phi", phi_inc_o, 0);
    checkOutput("arst_freq", freq_mod_o, 0);
    checkOutput("arst_clken", nco_clken_o, 0);
    checkOutput("arst_sym", sym_start_o, 0);
    checkOutput("arst_und", underrun_o, 0);
    checkOutput("arst_busy", busy_o, 0);
    checkOutput("arst_ready", bit_ready_o, 0);
    applyStimulus(0, 0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("post_rst_busy", busy_o, 0);
    checkOutput("post_rst_clken", nco_clken_o, 0);

    // Continuous supply of alternating bits for eight symbols.
    phi_base_i = PHI;
    dev_i      = DEV;
    applyStimulus(1, 1, 1, 1);
    @(negedge clk);
    @(negedge clk);
    #1 checkOutput("cont_first_ready", bit_ready_o, 1);
    xferBase = xfers;
    for (int s = 0; s < 8; s++) begin
      @(negedge clk);
      applyStimulus(1, 1, (s % 2 == 1), 1);
      checkSymbol($sformatf("cont%0d", s), (s % 2 == 0) ? DEV : NDEV, 0, (s == 7) ? 15 : -1, -1);
    end
    @(negedge clk);
    checkOutput("cont_xfers", xfers - xferBase, 8);
    repeat (8) @(negedge clk);
    checkOutput("cont_end_busy", busy_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
